// File: rtl/rvga_types.sv
// Shared rvga pipeline types: the control word carried between stages and its opcode encodings.
package rvga_types;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic            src2_imm_v;
    logic            br_v;
    logic [2:0]      br_op;
    logic            jmp_v;
    logic            jalr_v;
    logic            md_v;
    logic [2:0]      md_op;
  } rvga_cword;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Branch and mul/div encodings follow the RISC-V funct3 values.
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

endpackage

// File: rtl/execute_stage.sv
// rvga execute stage: ALU, branch/jump resolution and an iterative mul/div unit.
// Define RVGA_MULDIV_EN to build the mul/div FSM; otherwise md ops retire in one cycle with zero data.
module execute_stage
  import rvga_types::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_v_i,
  input  rvga_cword       cword_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_data_i,
  output rvga_cword       cword_o,
  output logic [XLEN-1:0] alu_data_o,
  output logic            br_taken_o,
  output logic [XLEN-1:0] br_target_o,
  output logic            stall_v_o
);

  logic [XLEN-1:0] op_b, alu_res, res_c, target_c, md_data_c;
  logic [4:0]      shamt;
  logic            br_cond, br_taken_c;

  rvga_cword       cword_q, cword_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d, br_target_q, br_target_d;
  logic            br_taken_q, br_taken_d;

  always_comb begin : alu
    op_b  = cword_i.src2_imm_v ? imm_data_i : rs2_data_i;
    shamt = op_b[4:0];
    case (cword_i.alu_op)
      ALU_ADD:  alu_res = rs1_data_i + op_b;
      ALU_SUB:  alu_res = rs1_data_i - op_b;
      ALU_SLL:  alu_res = rs1_data_i << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(rs1_data_i) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, rs1_data_i < op_b};
      ALU_XOR:  alu_res = rs1_data_i ^ op_b;
      ALU_SRL:  alu_res = rs1_data_i >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(rs1_data_i) >>> shamt);
      ALU_OR:   alu_res = rs1_data_i | op_b;
      ALU_AND:  alu_res = rs1_data_i & op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin : branch
    case (cword_i.br_op)
      BR_BEQ:  br_cond = (rs1_data_i == rs2_data_i);
      BR_BNE:  br_cond = (rs1_data_i != rs2_data_i);
      BR_BLT:  br_cond = ($signed(rs1_data_i) < $signed(rs2_data_i));
      BR_BGE:  br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      BR_BLTU: br_cond = (rs1_data_i < rs2_data_i);
      BR_BGEU: br_cond = (rs1_data_i >= rs2_data_i);
      default: br_cond = 1'b0;
    endcase
    br_taken_c = cword_i.v & (cword_i.jmp_v | (cword_i.br_v & br_cond));
    target_c   = (cword_i.jmp_v & cword_i.jalr_v)
               ? ((rs1_data_i + imm_data_i) & ~XLEN'(1))
               : (cword_i.pc + imm_data_i);
  end

`ifdef RVGA_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_e;

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, dz_q, dz_d;

  logic            md_start_c, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, md_res_c;
  logic [32:0]     mul_sum, div_rem, div_diff;
  logic [63:0]     prod;
  logic [XLEN-1:0] quo, rem;

  assign md_start_c = cword_i.v & cword_i.md_v;

  always_ff @(posedge clk_i or negedge rst_i) begin : md_regs
    if (!rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin : md_next_state
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_start_c) state_d = MD_BUSY;
      MD_BUSY: if (cnt_q == 5'd31) state_d = MD_DONE;
      MD_DONE: if (!stall_v_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Operands are held as magnitudes; the sign is reapplied once the unsigned iteration finishes.
  always_comb begin : md_datapath
    is_div   = cword_i.md_op[2];
    a_sgn    = is_div ? ~cword_i.md_op[0] : (cword_i.md_op[1:0] != 2'b11);
    b_sgn    = is_div ? ~cword_i.md_op[0] : ~cword_i.md_op[1];
    a_neg    = a_sgn & rs1_data_i[31];
    b_neg    = b_sgn & rs2_data_i[31];
    a_mag    = a_neg ? (XLEN'(0) - rs1_data_i) : rs1_data_i;
    b_mag    = b_neg ? (XLEN'(0) - rs2_data_i) : rs2_data_i;
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? m_q : XLEN'(0))};
    div_rem  = acc_q[63:31];
    div_diff = div_rem - {1'b0, m_q};
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    case (state_q)
      MD_IDLE: begin
        cnt_d = '0;
        if (md_start_c) begin
          acc_d = {32'd0, (is_div ? a_mag : b_mag)};
          m_d   = is_div ? b_mag : a_mag;
          op_d  = cword_i.md_op;
          neg_d = (is_div & cword_i.md_op[1]) ? a_neg : (a_neg ^ b_neg);
          dz_d  = (rs2_data_i == XLEN'(0));
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          acc_d = div_diff[32] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                               : {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin : md_result
    prod = neg_q ? (64'd0 - acc_q) : acc_q;
    quo  = neg_q ? (XLEN'(0) - acc_q[31:0]) : acc_q[31:0];
    rem  = neg_q ? (XLEN'(0) - acc_q[63:32]) : acc_q[63:32];
    case (op_q)
      MD_MUL:                       md_res_c = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res_c = prod[63:32];
      MD_DIV, MD_DIVU:              md_res_c = dz_q ? '1 : quo;
      default:                      md_res_c = rem;
    endcase
  end

  always_comb begin : md_outputs
    stall_v_o = rst_i & (((state_q == MD_IDLE) & md_start_c) |
                          (state_q == MD_BUSY) |
                          ((state_q == MD_DONE) & stall_v_i));
    md_data_c = (state_q == MD_DONE) ? md_res_c : '0;
  end
`else
  assign stall_v_o = 1'b0;
  assign md_data_c = '0;
`endif

  always_comb begin : result_mux
    if (cword_i.jmp_v)     res_c = cword_i.pc + XLEN'(4);
    else if (cword_i.md_v) res_c = md_data_c;
    else                   res_c = alu_res;
  end

  // Downstream stall freezes everything; our own stall turns the slot into a bubble.
  always_comb begin : out_next
    cword_d     = cword_q;
    alu_data_d  = alu_data_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    if (!stall_v_i) begin
      if (stall_v_o) begin
        cword_d     = '0;
        alu_data_d  = '0;
        br_taken_d  = 1'b0;
        br_target_d = '0;
      end else begin
        cword_d     = cword_i;
        alu_data_d  = res_c;
        br_taken_d  = br_taken_c;
        br_target_d = target_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin : out_regs
    if (!rst_i) begin
      cword_q     <= '0;
      alu_data_q  <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      cword_q     <= cword_d;
      alu_data_q  <= alu_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign cword_o     = cword_q;
  assign alu_data_o  = alu_data_q;
  assign br_taken_o  = br_taken_q;
  assign br_target_o = br_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed and random ops against a behavioural model of the stage.
module tb_execute_stage;
  import rvga_types::*;

  logic        clk_i, rst_i, stall_v_i, br_taken_o, stall_v_o;
  rvga_cword   cword_i, cword_o;
  logic [31:0] rs1_data_i, rs2_data_i, imm_data_i, alu_data_o, br_target_o;

  int          nvec, nerr;
  rvga_cword   exp_cw;
  logic [31:0] exp_data, exp_tgt;
  logic        exp_tk;

  execute_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_v_i   (stall_v_i),
    .cword_i     (cword_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .imm_data_i  (imm_data_i),
    .cword_o     (cword_o),
    .alu_data_o  (alu_data_o),
    .br_taken_o  (br_taken_o),
    .br_target_o (br_target_o),
    .stall_v_o   (stall_v_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input rvga_cword cw, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic st);
    cword_i    = cw;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_data_i = imm;
    stall_v_i  = st;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sx;
    sx = {{32{a[31]}}, a};
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  begin sx = sx >> b[4:0]; return sx[31:0]; end
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return $signed(a) < $signed(b);
      BR_BGE:  return $signed(a) >= $signed(b);
      BR_BLTU: return a < b;
      BR_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Full-width products and native division; the corner cases come straight from the ISA rules.
  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] q, r;
    logic        sgn;
    if (!op[2]) begin
      ea = (op == MD_MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
      eb = (op == MD_MUL || op == MD_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == MD_MUL) ? p[31:0] : p[63:32];
    end
    sgn = (op == MD_DIV || op == MD_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return (op == MD_DIV || op == MD_DIVU) ? q : r;
  endfunction

  function automatic rvga_cword rand_cw();
    rvga_cword  cw;
    logic [2:0] bops [6];
    int         k;
    bops = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
    cw            = '0;
    cw.v          = ($urandom_range(0, 4) != 0);
    cw.pc         = $urandom & 32'hFFFF_FFFC;
    cw.alu_op     = 4'($urandom_range(0, 9));
    cw.src2_imm_v = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 3);
    if (k == 1) begin
      cw.br_v  = 1'b1;
      cw.br_op = bops[$urandom_range(0, 5)];
    end else if (k == 2) begin
      cw.jmp_v  = 1'b1;
      cw.jalr_v = 1'($urandom_range(0, 1));
    end
    return cw;
  endfunction

  task automatic model_simple(input rvga_cword cw, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic st);
    logic [31:0] opb;
    if (!st) begin
      opb     = cw.src2_imm_v ? imm : b;
      exp_cw  = cw;
      exp_tk  = 1'b0;
      exp_tgt = cw.pc + imm;
      if (cw.jmp_v) begin
        exp_data = cw.pc + 32'd4;
        exp_tk   = cw.v;
        if (cw.jalr_v) exp_tgt = (a + imm) & 32'hFFFF_FFFE;
      end else if (cw.md_v) begin
        exp_data = 32'd0;
      end else begin
        exp_data = alu_ref(cw.alu_op, a, opb);
      end
      if (cw.br_v) exp_tk = cw.v & br_ref(cw.br_op, a, b);
    end
  endtask

  task automatic run_op(input rvga_cword cw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic st, input string tag);
    drive(cw, a, b, imm, st);
    model_simple(cw, a, b, imm, st);
    chk({tag, ".stall_o"}, 64'(stall_v_o), 64'(0));
    step();
    chk({tag, ".cword"}, 64'(cword_o), 64'(exp_cw));
    chk({tag, ".data"}, 64'(alu_data_o), 64'(exp_data));
    chk({tag, ".taken"}, 64'(br_taken_o), 64'(exp_tk));
    if (exp_tk) chk({tag, ".target"}, 64'(br_target_o), 64'(exp_tgt));
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    rvga_cword cw;
    int        n;
    cw        = '0;
    cw.v      = 1'b1;
    cw.md_v   = 1'b1;
    cw.md_op  = op;
    cw.pc     = $urandom & 32'hFFFF_FFFC;
    drive(cw, a, b, $urandom, 1'b0);
`ifdef RVGA_MULDIV_EN
    exp_data = md_ref(op, a, b);
    n = 0;
    while (stall_v_o === 1'b1 && n < 40) begin
      n++;
      step();
      chk({tag, ".bubble"}, 64'(cword_o == '0 && alu_data_o == 0 && !br_taken_o), 64'(1));
    end
    chk({tag, ".stall_cycles"}, 64'(n), 64'(33));
`else
    exp_data = 32'd0;
    chk({tag, ".stall_o"}, 64'(stall_v_o), 64'(0));
`endif
    step();
    exp_cw = cw;
    exp_tk = 1'b0;
    chk({tag, ".result"}, 64'(alu_data_o), 64'(exp_data));
    chk({tag, ".cword"}, 64'(cword_o), 64'(cw));
    chk({tag, ".taken"}, 64'(br_taken_o), 64'(0));
  endtask

  initial begin
    rvga_cword   cw;
    logic [31:0] a, b, imm;
    logic        st;
    int          n;
    nvec = 0; nerr = 0;
    exp_cw = '0; exp_data = '0; exp_tgt = '0; exp_tk = 1'b0;

    // Reset with a valid md op presented: no stall may leak out.
    rst_i = 1'b0;
    cw = '0; cw.v = 1'b1; cw.md_v = 1'b1; cw.md_op = MD_MUL;
    drive(cw, 32'd3, 32'd5, 32'd0, 1'b0);
    #3;
    chk("reset.cword", 64'(cword_o), 64'(0));
    chk("reset.data", 64'(alu_data_o), 64'(0));
    chk("reset.taken", 64'(br_taken_o), 64'(0));
    chk("reset.target", 64'(br_target_o), 64'(0));
    chk("reset.stall_o", 64'(stall_v_o), 64'(0));
    step();
    drive('0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    rst_i = 1'b1;

    cw = '0; cw.v = 1'b1; cw.alu_op = ALU_ADD; cw.src2_imm_v = 1'b1;
    run_op(cw, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b0, "add_ovf");
    chk("add_ovf.spec", 64'(alu_data_o), 64'h8000_0000);

    cw = '0; cw.v = 1'b1; cw.br_v = 1'b1; cw.br_op = BR_BLT; cw.pc = 32'h100;
    run_op(cw, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, "blt");
    chk("blt.spec_target", 64'(br_target_o), 64'h120);

    cw = '0; cw.v = 1'b1; cw.jmp_v = 1'b1; cw.jalr_v = 1'b1; cw.pc = 32'h40;
    run_op(cw, 32'h1003, 32'd0, 32'd4, 1'b0, "jalr");
    chk("jalr.spec_target", 64'(br_target_o), 64'h1006);
    chk("jalr.spec_link", 64'(alu_data_o), 64'h44);

    for (int i = 0; i < 200; i++) begin
      cw  = rand_cw();
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = $urandom;
      st  = ($urandom_range(0, 4) == 0);
      run_op(cw, a, b, imm, st, "rand");
    end

    run_md(MD_MULH, 32'h8000_0000, 32'h8000_0000, "mulh_min");
`ifdef RVGA_MULDIV_EN
    chk("mulh_min.spec", 64'(alu_data_o), 64'h4000_0000);
`endif
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
`ifdef RVGA_MULDIV_EN
    chk("div_ovf.spec", 64'(alu_data_o), 64'h8000_0000);
`endif
    run_md(MD_REM, 32'h1234, 32'd0, "rem_dz");
`ifdef RVGA_MULDIV_EN
    chk("rem_dz.spec", 64'(alu_data_o), 64'h1234);
`endif
    run_md(MD_DIVU, 32'hDEAD_BEEF, 32'd0, "divu_dz");
`ifdef RVGA_MULDIV_EN
    chk("divu_dz.spec", 64'(alu_data_o), 64'hFFFF_FFFF);
`endif

    // Back-to-back md ops with mixed signs.
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 300));
      b = ($urandom_range(0, 1) != 0) ? $urandom : (32'd0 - 32'($urandom_range(1, 9)));
      run_md(3'(i), a, b, "md_b2b");
    end
    cw = '0;
    run_op(cw, 32'd0, 32'd0, 32'd0, 1'b0, "md_drain");

`ifdef RVGA_MULDIV_EN
    // Downstream stall while DONE: result held back, then delivered once.
    cw = '0; cw.v = 1'b1; cw.md_v = 1'b1; cw.md_op = MD_MUL; cw.pc = 32'h200;
    drive(cw, 32'd3, 32'd5, 32'd0, 1'b0);
    n = 0;
    while (stall_v_o === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("mul_done.stall_cycles", 64'(n), 64'(33));
    stall_v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mul_done.held_stall", 64'(stall_v_o), 64'(1));
      step();
      chk("mul_done.held_out", 64'(cword_o), 64'(0));
    end
    stall_v_i = 1'b0;
    #1;
    chk("mul_done.release", 64'(stall_v_o), 64'(0));
    step();
    chk("mul_done.result", 64'(alu_data_o), 64'd15);
    chk("mul_done.cword", 64'(cword_o), 64'(cw));
    drive('0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("mul_done.once", 64'(cword_o), 64'(0));

    // Downstream stall while BUSY: outputs keep the last real result.
    cw = '0; cw.v = 1'b1; cw.alu_op = ALU_ADD;
    run_op(cw, 32'd5, 32'd6, 32'd0, 1'b0, "pre_busy");
    cw = '0; cw.v = 1'b1; cw.md_v = 1'b1; cw.md_op = MD_DIVU;
    drive(cw, 32'd100, 32'd7, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("busy_stall.stall_o", 64'(stall_v_o), 64'(1));
      step();
      chk("busy_stall.hold", 64'(alu_data_o), 64'd11);
    end
    stall_v_i = 1'b0;
    n = 0;
    while (stall_v_o === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("busy_stall.remaining", 64'(n), 64'(28));
    step();
    chk("busy_stall.result", 64'(alu_data_o), 64'd14);
`endif

    // Reset during iteration 10 of a multiply.
    cw = '0; cw.v = 1'b1; cw.md_v = 1'b1; cw.md_op = MD_MULH;
    drive(cw, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0);
    repeat (11) step();
`ifdef RVGA_MULDIV_EN
    chk("rst_mid.busy", 64'(stall_v_o), 64'(1));
`endif
    rst_i = 1'b0;
    #1;
    chk("rst_mid.cword", 64'(cword_o), 64'(0));
    chk("rst_mid.data", 64'(alu_data_o), 64'(0));
    chk("rst_mid.taken", 64'(br_taken_o), 64'(0));
    chk("rst_mid.stall_o", 64'(stall_v_o), 64'(0));
    step();
    cw = '0; cw.v = 1'b1; cw.alu_op = ALU_SUB;
    drive(cw, 32'd9, 32'd4, 32'd0, 1'b0);
    rst_i = 1'b1;
    run_op(cw, 32'd9, 32'd4, 32'd0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the rvga pipeline, directly downstream of the register-fetch stage. It takes the registered control word, operand data and immediate, and produces three results: the ALU result, the branch/jump resolution, and the result of an iterative M-extension multiply/divide unit. Results are registered into the next stage's control word and data. While a multi-cycle operation is in flight, the stage stalls upstream and inserts bubbles downstream.

## Interface
Parameters: none (widths fixed by `rvga_types`).

- `clk_i` — in — 1 — clock, rising edge.
- `rst_i` — in — 1 — reset, asynchronous, active-low.
- `stall_v_i` — in — 1 — downstream stall; all output registers hold.
- `cword_i` — in — `rvga_cword` — control word from register-fetch. Fields used: `v`, `pc`, `alu_op`, `src2_imm_v`, `br_v`, `br_op`, `jmp_v`, `jalr_v`, `md_v`, `md_op`.
- `rs1_data_i` — in — 32 — rs1 operand.
- `rs2_data_i` — in — 32 — rs2 operand.
- `imm_data_i` — in — 32 — constructed immediate.
- `cword_o` — out — `rvga_cword` — registered control word; a bubble is all-zero.
- `alu_data_o` — out — 32 — registered result (ALU, link address, or mul/div).
- `br_taken_o` — out — 1 — registered; redirect taken.
- `br_target_o` — out — 32 — registered redirect target.
- `stall_v_o` — out — 1 — combinational; upstream must hold `cword_i` and operands.

## Operation
- **Operands:** `op_a` = rs1; `op_b` = `src2_imm_v` ? imm : rs2.
- **ALU ops:** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount = `op_b[4:0]`.
  - Arithmetic is modulo 2^32.
- **Branches** (`br_v`): `br_op` selects BEQ, BNE, BLT, BGE, BLTU, BGEU on rs1 vs rs2.
  - Taken → target = pc + imm.
- **Jumps** (`jmp_v`): always taken; result = pc + 4.
  - JAL target = pc + imm.
  - JALR target = (rs1 + imm) & ~1.
- **Mul/div FSM:** states IDLE, BUSY, DONE; 5-bit iteration counter.
  - IDLE → BUSY when `cword_i.v & md_v`. Operands are latched as magnitudes, with sign flags per `md_op`.
  - BUSY: one radix-2 step per cycle; counter 0..31.
    - MUL*: shift-add.
    - DIV*/REM*: restoring divide.
    - Counter = 31 → DONE.
  - DONE: final sign correction is applied.
    - `~stall_v_i` → result loaded into output registers, FSM → IDLE.
    - `stall_v_i` → stay in DONE.
  - Result selection: MUL = low 32 bits of the product; MULH/MULHSU/MULHU = high 32 bits with the respective signedness.
  - Divide by zero: quotient = 0xFFFF_FFFF, remainder = dividend.
  - Signed overflow (0x8000_0000 / -1): quotient = 0x8000_0000, remainder = 0.
- **stall_v_o** = (IDLE & `cword_i.v` & `md_v`) | BUSY | (DONE & `stall_v_i`).
- **Output register update:**
  - `stall_v_i` high: hold all outputs, regardless of FSM state.
  - Else `stall_v_o` high: load a bubble (`cword_o` = 0, `br_taken_o` = 0, data = 0).
  - Else: load the computed result and `cword_i`.
  - A non-valid input (`cword_i.v` = 0) produces `br_taken_o` = 0.

## Timing
- Reset values: `cword_o` = 0, `alu_data_o` = 0, `br_taken_o` = 0, `br_target_o` = 0, FSM = IDLE, counter = 0. `stall_v_o` = 0 while in reset.
- ALU, branch and jump: 1-cycle latency (inputs at edge t, outputs valid after edge t+1).
- Mul/div timing, accepted in IDLE at cycle t:
  - BUSY in cycles t+1..t+32; DONE in cycle t+33.
  - Result on outputs after edge t+34, when `stall_v_i` is low throughout.
  - `stall_v_o` is high for cycles t..t+32 (33 cycles).
- Downstream stall in DONE extends the DONE state. The result is never lost or duplicated.
- Downstream stall during BUSY: the iteration continues, and the outputs hold their previous value, not a bubble.
- Reset asserted mid-operation: immediately aborts to IDLE; outputs take their reset values.
- A mul/div op immediately following another: the second one enters from IDLE in the cycle after DONE, with no gap beyond that single cycle.

## Configuration
- `RVGA_MULDIV_EN` defined: the mul/div FSM and datapath are compiled in, as described above.
- Undefined: no FSM, no counter. `stall_v_o` is tied to 0. A `md_v` op completes in 1 cycle with `alu_data_o` = 0 and `cword_o` passed through.

## Test plan
- ADD, rs1 = 0x7FFF_FFFF, `op_b` = imm = 1 → `alu_data_o` = 0x8000_0000 one cycle later; `br_taken_o` = 0.
- BLT, rs1 = 0xFFFF_FFFF, rs2 = 1, pc = 0x100, imm = 0x20 → `br_taken_o` = 1, `br_target_o` = 0x120.
- JALR, rs1 = 0x1003, imm = 4, pc = 0x40 → target 0x1006, `alu_data_o` = 0x44, `br_taken_o` = 1.
- MULH, 0x8000_0000 × 0x8000_0000 → `stall_v_o` high for 33 cycles, 33 bubbles out, then `alu_data_o` = 0x4000_0000.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM with divisor 0, dividend 0x1234 → 0x1234. DIVU by 0 → 0xFFFF_FFFF.
- MUL 3 × 5 with `stall_v_i` held high 4 cycles during DONE → FSM stays in DONE, result 15 appears exactly once. Reset at BUSY iteration 10 → IDLE, all outputs 0.
